mem_stage_ctrl: RTL and testbench

- Memory-stage responder for the decoder's memory control bits: DMR, DMW, stack_operation and push_pop.
- Accepts one decoded memory command per handshake and owns the stack pointer (SP).
- Runs a request/ready transaction to data memory and holds the pipeline stalled until the access completes.
- Sits between the EX/MEM pipeline register and the data memory; its results feed MEM/WB.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_stage_ctrl_if.sv | 30 +++
 rtl/stack_ptr.sv | 49 ++++
 rtl/mem_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory-stage controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STORE = 3'd2,
        CMD_PUSH  = 3'd3,
        CMD_POP   = 3'd4
    } mem_cmd_t;

    // Illegal: both strobes, or a stack direction that disagrees with the strobe.
    function automatic logic is_illegal(input logic dmr, input logic dmw,
                                        input logic stk, input logic push);
        return (dmr && dmw) || (stk && (dmr ^ dmw) && (push != dmw));
    endfunction

    function automatic mem_cmd_t decode_cmd(input logic dmr, input logic dmw,
                                            input logic stk, input logic push);
        mem_cmd_t cmd;
        cmd = CMD_NONE;
        if (dmr ^ dmw) begin
            if (!stk)
                cmd = dmr ? CMD_LOAD : CMD_STORE;
            else if (push && dmw)
                cmd = CMD_PUSH;
            else if (!push && dmr)
                cmd = CMD_POP;
        end
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
// ============================================================================
// Module      : mem_stage_ctrl_if
// Description : Request/ready data-memory bus between the controller and RAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/stack_ptr.sv
// ============================================================================
// Module      : stack_ptr
// Description : Downward-growing stack pointer with wrap and sticky flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stack_ptr #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              upd,
    input  wire logic              push,
    output logic      [ADDR_W-1:0] sp,
    output logic      [ADDR_W-1:0] pop_addr,
    output logic                   ovf,
    output logic                   unf
);
    logic [ADDR_W-1:0] r_sp;
    logic              r_ovf;
    logic              r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp  <= SP_INIT;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (upd) begin
            if (push) begin
                r_sp <= r_sp - ADDR_W'(1);
                if (r_sp == '0)
                    r_ovf <= 1'b1;
            end else begin
                r_sp <= r_sp + ADDR_W'(1);
                if (r_sp == '1)
                    r_unf <= 1'b1;
            end
        end
    end

    assign sp       = r_sp;
    assign pop_addr = r_sp + ADDR_W'(1);
    assign ovf      = r_ovf;
    assign unf      = r_unf;
endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage responder: loads, stores, push/pop with timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int                DATA_W  = mem_pkg::DATA_W,
    parameter int                ADDR_W  = mem_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}},
    parameter int                TIMEOUT = 15
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic              DMR,
    input  wire logic              DMW,
    input  wire logic              stack_operation,
    input  wire logic              push_pop,
    input  wire logic [ADDR_W-1:0] addr_in,
    input  wire logic [DATA_W-1:0] wdata_in,
    output logic                   stall,
    output logic                   out_valid,
    output logic      [DATA_W-1:0] rdata_out,
    output logic                   err,
    output logic      [ADDR_W-1:0] sp,
    output logic                   stk_ovf,
    output logic                   stk_unf,
    mem_stage_ctrl_if.master       mem
);
    import mem_pkg::*;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            r_state,  w_state;
    mem_cmd_t          r_cmd,    w_cmd;
    logic              r_req,    w_req;
    logic              r_we,     w_we;
    logic [ADDR_W-1:0] r_addr,   w_addr;
    logic [DATA_W-1:0] r_wdata,  w_wdata;
    logic [DATA_W-1:0] r_cap,    w_cap;
    logic [CNT_W-1:0]  r_cnt,    w_cnt;
    logic              r_stall,  w_stall;
    logic              r_valid,  w_valid;
    logic              r_err,    w_err;
    logic [DATA_W-1:0] r_rdata,  w_rdata;
    logic              w_sp_upd;
    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_pop_addr;
    mem_cmd_t          w_dec;

    stack_ptr #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_stack_ptr (
        .clk      (clk),
        .rst      (rst),
        .upd      (w_sp_upd),
        .push     (r_cmd == CMD_PUSH),
        .sp       (w_sp),
        .pop_addr (w_pop_addr),
        .ovf      (stk_ovf),
        .unf      (stk_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cmd   <= CMD_NONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cap   <= '0;
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state;
            r_cmd   <= w_cmd;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cap   <= w_cap;
            r_cnt   <= w_cnt;
            r_stall <= w_stall;
            r_valid <= w_valid;
            r_err   <= w_err;
            r_rdata <= w_rdata;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cmd    = r_cmd;
        w_req    = r_req;
        w_we     = r_we;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_cap    = r_cap;
        w_cnt    = r_cnt;
        w_stall  = r_stall;
        w_valid  = 1'b0;
        w_err    = 1'b0;
        w_rdata  = '0;
        w_sp_upd = 1'b0;
        w_dec    = decode_cmd(DMR, DMW, stack_operation, push_pop);

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (is_illegal(DMR, DMW, stack_operation, push_pop)) begin
                        w_err = 1'b1;
                    end else if (w_dec != CMD_NONE) begin
                        w_state = ACCESS;
                        w_cmd   = w_dec;
                        w_req   = 1'b1;
                        w_stall = 1'b1;
                        w_cnt   = '0;
                        w_we    = (w_dec == CMD_STORE) || (w_dec == CMD_PUSH);
                        w_wdata = w_we ? wdata_in : '0;
                        case (w_dec)
                            CMD_PUSH: w_addr = w_sp;
                            CMD_POP:  w_addr = w_pop_addr;
                            default:  w_addr = addr_in;
                        endcase
                    end
                end
            end
            ACCESS: begin
                if (mem.mem_ready) begin
                    w_state  = RESP;
                    w_req    = 1'b0;
                    w_we     = 1'b0;
                    w_cap    = r_we ? '0 : mem.mem_rdata;
                    w_sp_upd = (r_cmd == CMD_PUSH) || (r_cmd == CMD_POP);
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: the command is dropped and SP is left untouched.
                    w_state = IDLE;
                    w_req   = 1'b0;
                    w_we    = 1'b0;
                    w_stall = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state = IDLE;
                w_valid = 1'b1;
                w_rdata = r_cap;
                w_stall = 1'b0;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign stall         = r_stall;
    assign out_valid     = r_valid;
    assign rdata_out     = r_rdata;
    assign err           = r_err;
    assign sp            = w_sp;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Scoreboard bench for mem_stage_ctrl with a scripted memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        DMR = 1'b0;
    logic        DMW = 1'b0;
    logic        stack_operation = 1'b0;
    logic        push_pop = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] wdata_in = '0;
    logic        stall, out_valid, err, stk_ovf, stk_unf;
    logic [15:0] rdata_out, sp;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .SP_INIT(16'hFFFF), .TIMEOUT(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .DMR             (DMR),
        .DMW             (DMW),
        .stack_operation (stack_operation),
        .push_pop        (push_pop),
        .addr_in         (addr_in),
        .wdata_in        (wdata_in),
        .stall           (stall),
        .out_valid       (out_valid),
        .rdata_out       (rdata_out),
        .err             (err),
        .sp              (sp),
        .stk_ovf         (stk_ovf),
        .stk_unf         (stk_unf),
        .mem             (mif.master)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] rdata;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic [15:0] addr;
        bit          we;
        logic [15:0] wd;
    } acc_t;

    resp_t       resp_q[$];
    acc_t        acc_q[$];
    resp_t       got;
    acc_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_delay = -1;
    logic [15:0] mem_data  = '0;
    int          req_cnt   = 0;
    int          last_req_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every completion or error pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (out_valid || err)) begin
            if (resp_q.size() == 0) begin
                check("unexpected_response", {30'b0, err, out_valid}, 32'd0);
            end else begin
                got = resp_q.pop_front();
                check("resp_kind", {30'b0, err, out_valid}, got.is_err ? 32'd2 : 32'd1);
                if (!got.is_err)
                    check("rdata_out", {16'b0, rdata_out}, {16'b0, got.rdata});
                if (got.lat >= 0)
                    check("latency", cyc - got.t0, got.lat);
            end
        end
    end

    // Memory model: answers after mem_delay extra cycles; -1 never answers.
    always @(negedge clk) begin
        if (mif.mem_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    cur = acc_q.pop_front();
                    check("mem_addr", {16'b0, mif.mem_addr}, {16'b0, cur.addr});
                    check("mem_we", {31'b0, mif.mem_we}, {31'b0, cur.we});
                    if (cur.we)
                        check("mem_wdata", {16'b0, mif.mem_wdata}, {16'b0, cur.wd});
                end
            end else begin
                check("mem_addr_stable", {16'b0, mif.mem_addr}, {16'b0, cur.addr});
            end
            check("stall_in_access", {31'b0, stall}, 32'd1);
            mif.mem_ready = (mem_delay >= 0) && (req_cnt == mem_delay + 1);
        end else begin
            if (req_cnt > 0)
                last_req_len = req_cnt;
            req_cnt       = 0;
            mif.mem_ready = 1'b0;
        end
        mif.mem_rdata = mem_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_resp(input bit is_err, input logic [15:0] rd, input int lat);
        resp_t r;
        r.is_err = is_err;
        r.rdata  = rd;
        r.lat    = lat;
        r.t0     = cyc;
        resp_q.push_back(r);
    endtask

    task automatic exp_acc(input logic [15:0] a, input bit we, input logic [15:0] wd);
        acc_t x;
        x.addr = a;
        x.we   = we;
        x.wd   = wd;
        acc_q.push_back(x);
    endtask

    task automatic issue(input bit dmr, input bit dmw, input bit stk, input bit pp,
                         input logic [15:0] a, input logic [15:0] wd);
        in_valid = 1'b1; DMR = dmr; DMW = dmw; stack_operation = stk; push_pop = pp;
        addr_in = a; wdata_in = wd;
        tick(1);
        in_valid = 1'b0; DMR = 1'b0; DMW = 1'b0; stack_operation = 1'b0; push_pop = 1'b0;
        addr_in = '0; wdata_in = '0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((stall || resp_q.size() != 0) && i < budget) begin
            tick(1);
            i++;
        end
        if (i >= budget)
            check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        tick(3);
        check("rst_sp", {16'b0, sp}, 32'h0000_FFFF);
        check("rst_outputs", {26'b0, stall, out_valid, err, stk_ovf, stk_unf, mif.mem_req}, 32'd0);
        check("rst_bus", {mif.mem_addr, rdata_out}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Push 0xBEEF, immediate ready, then a back-to-back pop.
        mem_delay = 0;
        exp_acc(16'hFFFF, 1'b1, 16'hBEEF);
        exp_resp(1'b0, 16'h0000, 3);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hBEEF);
        tick(2);
        check("sp_after_push", {16'b0, sp}, 32'h0000_FFFE);
        mem_data = 16'hBEEF;
        exp_acc(16'hFFFF, 1'b0, 16'h0000);
        exp_resp(1'b0, 16'hBEEF, 3);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        drain(20);
        check("sp_after_pop", {16'b0, sp}, 32'h0000_FFFF);

        // LDD with mem_ready five cycles late.
        mem_delay = 5;
        mem_data  = 16'h1234;
        exp_acc(16'h0040, 1'b0, 16'h0000);
        exp_resp(1'b0, 16'h1234, 8);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        drain(30);
        check("ldd_req_len", last_req_len, 32'd6);

        // Pop from a fresh SP wraps to zero; push at zero wraps back.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        mem_delay = 0;
        mem_data  = 16'h5A5A;
        exp_acc(16'h0000, 1'b0, 16'h0000);
        exp_resp(1'b0, 16'h5A5A, 3);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        drain(20);
        check("sp_unf_wrap", {16'b0, sp}, 32'h0000_0000);
        check("flags_after_unf", {30'b0, stk_ovf, stk_unf}, 32'd1);
        exp_acc(16'h0000, 1'b1, 16'h1111);
        exp_resp(1'b0, 16'h0000, 3);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111);
        drain(20);
        check("sp_ovf_wrap", {16'b0, sp}, 32'h0000_FFFF);
        check("flags_after_ovf", {30'b0, stk_ovf, stk_unf}, 32'd3);

        // Illegal commands pulse err without touching memory; stack-op alone is ignored.
        exp_resp(1'b1, 16'h0000, 1);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        drain(10);
        exp_resp(1'b1, 16'h0000, 1);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        drain(10);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        tick(2);
        check("ignored_no_stall", {31'b0, stall}, 32'd0);

        // STD that never completes times out after 15 access cycles.
        mem_delay = -1;
        exp_acc(16'h0100, 1'b1, 16'hCAFE);
        exp_resp(1'b1, 16'h0000, 16);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hCAFE);
        drain(40);
        check("timeout_req_len", last_req_len, 32'd15);
        check("timeout_sp", {16'b0, sp}, 32'h0000_FFFF);

        // Reset two cycles into ACCESS aborts cleanly.
        exp_acc(16'h0200, 1'b0, 16'h0000);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_req", {31'b0, mif.mem_req}, 32'd0);
        check("abort_state", {29'b0, stall, stk_ovf, stk_unf}, 32'd0);
        check("abort_sp", {16'b0, sp}, 32'h0000_FFFF);
        tick(1);

        mem_delay = 1;
        mem_data  = 16'h7777;
        exp_acc(16'h0002, 1'b0, 16'h0000);
        exp_resp(1'b0, 16'h7777, 4);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000);
        drain(20);
        tick(2);

        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("acc_queue_empty", acc_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
